// File: rtl/dmem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported data memory.
// Generates byte enables, rejects misaligned accesses and aligns/extends load data.
module dmem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // master 0: CPU MEM stage
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [1:0]            i_m0_size,
  input  logic                  i_m0_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_gnt,
  output logic                  o_m0_err,
  output logic                  o_m0_rvalid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  // master 1: debug / DMA
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [1:0]            i_m1_size,
  input  logic                  i_m1_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_err,
  output logic                  o_m1_rvalid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  // data memory
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_byte_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned SZ_W = 2;
  localparam int unsigned BE_W = 4;
  localparam logic [SZ_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SZ_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SZ_W-1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;

  // latched access of the current winner
  logic            r_id;
  logic            r_we;
  logic            r_unsigned;
  logic            r_illegal;
  logic [SZ_W-1:0] r_size;
  logic [1:0]      r_lane;

  // registered outputs
  logic                  r_m0_gnt;
  logic                  r_m0_err;
  logic                  r_m0_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic                  r_m1_gnt;
  logic                  r_m1_err;
  logic                  r_m1_rvalid;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [BE_W-1:0]       r_mem_byte_en;

  // arbitration and winner field selection
  logic                  w_any_req;
  logic                  w_win_id;
  logic                  w_win_we;
  logic                  w_win_unsigned;
  logic [SZ_W-1:0]       w_win_size;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  always_comb begin
    w_any_req      = i_m0_req | i_m1_req;
    w_win_id       = 1'b0;
    w_win_we       = i_m0_we;
    w_win_unsigned = i_m0_unsigned;
    w_win_size     = i_m0_size;
    w_win_addr     = i_m0_addr;
    w_win_wdata    = i_m0_wdata;
    if (i_m0_req && i_m1_req) begin
      w_win_id = ~r_last_grant;
    end else begin
      w_win_id = i_m1_req;
    end
    if (w_win_id) begin
      w_win_we       = i_m1_we;
      w_win_unsigned = i_m1_unsigned;
      w_win_size     = i_m1_size;
      w_win_addr     = i_m1_addr;
      w_win_wdata    = i_m1_wdata;
    end
  end

  // byte enables and alignment check for the winning access
  logic [BE_W-1:0] w_be;
  logic            w_illegal;

  always_comb begin
    w_be      = '0;
    w_illegal = 1'b0;
    case (w_win_size)
      SZ_BYTE: w_be = 4'b0001 << w_win_addr[1:0];
      SZ_HALF: begin
        w_be      = w_win_addr[1] ? 4'b1100 : 4'b0011;
        w_illegal = w_win_addr[0];
      end
      SZ_WORD: begin
        w_be      = 4'b1111;
        w_illegal = (w_win_addr[1:0] != 2'b00);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // next-state logic
  logic w_accept;
  logic w_issue_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we || r_illegal) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_issue_ok = w_accept & ~w_illegal;
  end

  // lane extraction and sign/zero extension of the read data
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  always_comb begin
    w_byte      = 8'h00;
    w_half      = i_mem_rdata[15:0];
    w_load_data = i_mem_rdata;
    case (r_lane)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    if (r_lane[1]) begin
      w_half = i_mem_rdata[31:16];
    end
    case (r_size)
      SZ_BYTE: w_load_data = r_unsigned ? DATA_WIDTH'(w_byte)
                                        : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = r_unsigned ? DATA_WIDTH'(w_half)
                                        : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last_grant <= w_win_id;
      end
    end
  end

  // datapath and output registers; outputs are computed one cycle ahead
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id          <= 1'b0;
      r_we          <= 1'b0;
      r_unsigned    <= 1'b0;
      r_illegal     <= 1'b0;
      r_size        <= '0;
      r_lane        <= '0;
      r_m0_gnt      <= 1'b0;
      r_m0_err      <= 1'b0;
      r_m0_rvalid   <= 1'b0;
      r_m0_rdata    <= '0;
      r_m1_gnt      <= 1'b0;
      r_m1_err      <= 1'b0;
      r_m1_rvalid   <= 1'b0;
      r_m1_rdata    <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_byte_en <= '0;
    end else begin
      r_m0_gnt    <= w_accept & ~w_win_id;
      r_m1_gnt    <= w_accept & w_win_id;
      r_m0_err    <= w_accept & ~w_win_id & w_illegal;
      r_m1_err    <= w_accept & w_win_id & w_illegal;
      r_mem_rd    <= w_issue_ok & ~w_win_we;
      r_mem_wr    <= w_issue_ok & w_win_we;
      r_m0_rvalid <= (r_state == S_WAIT) & ~r_id;
      r_m1_rvalid <= (r_state == S_WAIT) & r_id;
      if (w_accept) begin
        r_id       <= w_win_id;
        r_we       <= w_win_we;
        r_unsigned <= w_win_unsigned;
        r_illegal  <= w_illegal;
        r_size     <= w_win_size;
        r_lane     <= w_win_addr[1:0];
      end
      // memory address/data only move on a real access so they hold otherwise
      if (w_issue_ok) begin
        r_mem_addr    <= w_win_addr;
        r_mem_wdata   <= w_win_wdata;
        r_mem_byte_en <= w_be;
      end
      if (r_state == S_WAIT) begin
        if (r_id) begin
          r_m1_rdata <= w_load_data;
        end else begin
          r_m0_rdata <= w_load_data;
        end
      end
    end
  end

  assign o_m0_gnt      = r_m0_gnt;
  assign o_m0_err      = r_m0_err;
  assign o_m0_rvalid   = r_m0_rvalid;
  assign o_m0_rdata    = r_m0_rdata;
  assign o_m1_gnt      = r_m1_gnt;
  assign o_m1_err      = r_m1_err;
  assign o_m1_rvalid   = r_m1_rvalid;
  assign o_m1_rdata    = r_m1_rdata;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_wr      = r_mem_wr;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_byte_en = r_mem_byte_en;

endmodule
